// File: rtl/bcm_plane_shifter_if.sv
// rtl/bcm_plane_shifter_if.sv - frame-buffer read and HUB75 panel signals of the BCM plane shifter
interface bcm_plane_shifter_if #(
  parameter int ADDR_W  = 6,
  parameter int PLANES  = 4,
  parameter int PLANE_W = 2
);
  logic                  in_START;
  logic [PLANE_W-1:0]    in_PLANE;
  logic [ADDR_W-1:0]     out_RD_ADDR;
  logic [6*PLANES-1:0]   in_RD_DATA;
  logic [5:0]            out_RGB;
  logic                  out_SCLK;
  logic                  out_LATCH;
  logic                  out_OE_N;
  logic                  out_BUSY;
  logic                  out_DONE;

  modport master (
    output in_START, in_PLANE, in_RD_DATA,
    input  out_RD_ADDR, out_RGB, out_SCLK, out_LATCH, out_OE_N, out_BUSY, out_DONE
  );

  modport slave (
    input  in_START, in_PLANE, in_RD_DATA,
    output out_RD_ADDR, out_RGB, out_SCLK, out_LATCH, out_OE_N, out_BUSY, out_DONE
  );
endinterface

// File: rtl/bcm_plane_shifter.sv
// rtl/bcm_plane_shifter.sv - shifts one bit-plane of a frame-buffer row to a HUB75 panel
// Three cycles per column (FETCH, LOAD, CLK_HI), then LATCH, POST and a one-cycle DONE.
module bcm_plane_shifter #(
  parameter int COLS    = 64,
  parameter int ADDR_W  = 6,
  parameter int PLANES  = 4,
  parameter int PLANE_W = 2
) (
  input  logic               clk,
  input  logic               rst,
  bcm_plane_shifter_if.slave bus
);

  localparam int B_IDLE   = 0;
  localparam int B_FETCH  = 1;
  localparam int B_LOAD   = 2;
  localparam int B_CLK_HI = 3;
  localparam int B_LATCH  = 4;
  localparam int B_POST   = 5;
  localparam int B_DONE   = 6;

  localparam logic [6:0] S_IDLE   = 7'b0000001;
  localparam logic [6:0] S_FETCH  = 7'b0000010;
  localparam logic [6:0] S_LOAD   = 7'b0000100;
  localparam logic [6:0] S_CLK_HI = 7'b0001000;
  localparam logic [6:0] S_LATCH  = 7'b0010000;
  localparam logic [6:0] S_POST   = 7'b0100000;
  localparam logic [6:0] S_DONE   = 7'b1000000;

  localparam logic [ADDR_W-1:0] LAST_COL = ADDR_W'(COLS - 1);

  logic [6:0]         state;
  logic [ADDR_W-1:0]  col;
  logic [PLANE_W-1:0] plane;
  logic [5:0]         rgb;
  logic [5:0]         rgb_next;
  logic               shown;

  always_comb begin
    rgb_next = rgb;
    for (int c = 0; c < 6; c++) begin
      rgb_next[c] = bus.in_RD_DATA[c*PLANES + int'(plane)];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      col   <= '0;
      plane <= '0;
      rgb   <= '0;
      shown <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.in_START) begin
            plane <= bus.in_PLANE;
            col   <= '0;
            state <= S_FETCH;
          end
        end
        S_FETCH: state <= S_LOAD;
        S_LOAD: begin
          rgb   <= rgb_next;
          state <= S_CLK_HI;
        end
        S_CLK_HI: begin
          if (col == LAST_COL) begin
            state <= S_LATCH;
          end else begin
            col   <= col + ADDR_W'(1);
            state <= S_FETCH;
          end
        end
        S_LATCH: state <= S_POST;
        S_POST: begin
          shown <= 1'b1;
          state <= S_DONE;
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // One-hot state bits drive the panel strobes directly, so they cannot glitch.
  assign bus.out_SCLK    = state[B_CLK_HI];
  assign bus.out_LATCH   = state[B_LATCH];
  assign bus.out_DONE    = state[B_DONE];
  assign bus.out_BUSY    = ~state[B_IDLE];
  assign bus.out_OE_N    = ~shown | state[B_LATCH] | state[B_POST];
  assign bus.out_RD_ADDR = col;
  assign bus.out_RGB     = rgb;

  logic unused_ok;
  assign unused_ok = &{1'b0, state[B_FETCH], state[B_LOAD]};

endmodule

// File: tb/tb_bcm_plane_shifter.sv
// tb/tb_bcm_plane_shifter.sv - scoreboard bench for bcm_plane_shifter (COLS=4 and COLS=64 instances)
module tb_bcm_plane_shifter;

  typedef struct {
    int         kind;   // 0 SCLK high, 1 LATCH, 2 DONE
    int         cyc;
    logic [5:0] rgb;
    int         addr;
    logic       oe_n;
  } ev_t;

  logic clk = 1'b0;
  logic rst4, rst64;
  int   cyc = 0;
  int   vectors = 0;
  int   miscompares = 0;
  ev_t  q4[$];
  ev_t  q64[$];
  logic shown4 = 1'b0;
  logic shown64 = 1'b0;
  logic [5:0] tab4 [4];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  bcm_plane_shifter_if #(.ADDR_W(2), .PLANES(4), .PLANE_W(2)) if4 ();
  bcm_plane_shifter_if #(.ADDR_W(6), .PLANES(4), .PLANE_W(2)) if64 ();

  bcm_plane_shifter #(.COLS(4), .ADDR_W(2), .PLANES(4), .PLANE_W(2)) u4 (
    .clk(clk), .rst(rst4), .bus(if4)
  );
  bcm_plane_shifter #(.COLS(64), .ADDR_W(6), .PLANES(4), .PLANE_W(2)) u64 (
    .clk(clk), .rst(rst64), .bus(if64)
  );

  function automatic logic [23:0] word4(input int k);
    logic [3:0]  kk;
    logic [23:0] w;
    kk = k[3:0];
    w = '0;
    w[3:0] = kk;
    w[7:4] = ~kk;
    return w;
  endfunction

  function automatic logic [23:0] word64(input int k);
    logic [23:0] w;
    for (int c = 0; c < 6; c++) w[c*4 +: 4] = 4'(k + 5*c);
    return w;
  endfunction

  function automatic logic [5:0] exp64(input int k, input int p);
    logic [23:0] w;
    logic [5:0]  r;
    w = word64(k);
    for (int c = 0; c < 6; c++) r[c] = w[c*4 + p];
    return r;
  endfunction

  always @(posedge clk) begin
    if4.in_RD_DATA  <= word4(int'(if4.out_RD_ADDR));
    if64.in_RD_DATA <= word64(int'(if64.out_RD_ADDR));
  end

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic wait_cyc(input int n);
    while (cyc < n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic push4(input int t);
    ev_t e;
    for (int k = 0; k < 4; k++) begin
      e = '{0, t + 3 + 3*k, tab4[k], k, ~shown4};
      q4.push_back(e);
    end
    e = '{1, t + 13, 6'd0, 3, 1'b1};
    q4.push_back(e);
    e = '{2, t + 15, 6'd0, 3, 1'b0};
    q4.push_back(e);
    shown4 = 1'b1;
  endtask

  task automatic push64(input int t, input int p, input int last);
    ev_t e;
    for (int k = 0; k < 64; k++) begin
      if (t + 3 + 3*k <= last) begin
        e = '{0, t + 3 + 3*k, exp64(k, p), k, ~shown64};
        q64.push_back(e);
      end
    end
    if (t + 195 <= last) begin
      e = '{1, t + 193, 6'd0, 63, 1'b1};
      q64.push_back(e);
      e = '{2, t + 195, 6'd0, 63, 1'b0};
      q64.push_back(e);
      shown64 = 1'b1;
    end
  endtask

  task automatic idle_checks(input string who, input logic sclk, input logic latch,
                             input logic done, input logic busy, input logic oe_n,
                             input logic [5:0] rgb, input int addr);
    check({who, " sclk idle"}, int'(sclk), 0);
    check({who, " latch idle"}, int'(latch), 0);
    check({who, " done idle"}, int'(done), 0);
    check({who, " busy idle"}, int'(busy), 0);
    check({who, " oe_n idle"}, int'(oe_n), 1);
    check({who, " rgb idle"}, int'(rgb), 0);
    check({who, " rd_addr idle"}, addr, 0);
  endtask

  ev_t e4, e64;
  int  kind4, kind64;

  always @(negedge clk) begin
    if (if4.out_SCLK === 1'b1 || if4.out_LATCH === 1'b1 || if4.out_DONE === 1'b1) begin
      kind4 = if4.out_SCLK ? 0 : (if4.out_LATCH ? 1 : 2);
      if (q4.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL dut4 unexpected event: got kind %0d expected none (cycle %0d)", kind4, cyc);
      end else begin
        e4 = q4.pop_front();
        check("dut4 event kind", kind4, e4.kind);
        check("dut4 event cycle", cyc, e4.cyc);
        check("dut4 rd_addr", int'(if4.out_RD_ADDR), e4.addr);
        check("dut4 oe_n", int'(if4.out_OE_N), int'(e4.oe_n));
        check("dut4 busy", int'(if4.out_BUSY), 1);
        if (kind4 == 0) check("dut4 rgb", int'(if4.out_RGB), int'(e4.rgb));
      end
    end
  end

  always @(negedge clk) begin
    if (if64.out_SCLK === 1'b1 || if64.out_LATCH === 1'b1 || if64.out_DONE === 1'b1) begin
      kind64 = if64.out_SCLK ? 0 : (if64.out_LATCH ? 1 : 2);
      if (q64.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL dut64 unexpected event: got kind %0d expected none (cycle %0d)", kind64, cyc);
      end else begin
        e64 = q64.pop_front();
        check("dut64 event kind", kind64, e64.kind);
        check("dut64 event cycle", cyc, e64.cyc);
        check("dut64 rd_addr", int'(if64.out_RD_ADDR), e64.addr);
        check("dut64 oe_n", int'(if64.out_OE_N), int'(e64.oe_n));
        check("dut64 busy", int'(if64.out_BUSY), 1);
        if (kind64 == 0) check("dut64 rgb", int'(if64.out_RGB), int'(e64.rgb));
      end
    end
  end

  initial begin
    int t;
    tab4[0] = 6'b000010;
    tab4[1] = 6'b000010;
    tab4[2] = 6'b000001;
    tab4[3] = 6'b000001;
    rst4 = 1'b1;
    rst64 = 1'b1;
    if4.in_START = 1'b0;
    if4.in_PLANE = 2'd0;
    if64.in_START = 1'b0;
    if64.in_PLANE = 2'd0;
    repeat (3) @(posedge clk);
    #1;
    rst4 = 1'b0;
    rst64 = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    idle_checks("dut4", if4.out_SCLK, if4.out_LATCH, if4.out_DONE, if4.out_BUSY,
                if4.out_OE_N, if4.out_RGB, int'(if4.out_RD_ADDR));
    idle_checks("dut64", if64.out_SCLK, if64.out_LATCH, if64.out_DONE, if64.out_BUSY,
                if64.out_OE_N, if64.out_RGB, int'(if64.out_RD_ADDR));

    // Four-column plane 1, twice: the second pass runs with the first plane on display.
    for (int r = 0; r < 2; r++) begin
      t = cyc;
      if4.in_PLANE = 2'd1;
      if4.in_START = 1'b1;
      push4(t);
      @(posedge clk); #1;
      if4.in_START = 1'b0;
      wait_cyc(t + 18);
    end

    t = cyc;
    if64.in_PLANE = 2'd3;
    if64.in_START = 1'b1;
    push64(t, 3, 1 << 30);
    @(posedge clk); #1;
    if64.in_START = 1'b0;
    check("dut64 busy at t+1", int'(if64.out_BUSY), 1);
    wait_cyc(t + 195);
    check("dut64 busy at t+195", int'(if64.out_BUSY), 1);
    @(posedge clk); #1;
    check("dut64 busy at t+196", int'(if64.out_BUSY), 0);
    check("dut64 oe_n after done", int'(if64.out_OE_N), 0);

    // Start held high: second run begins the cycle after DONE, spacing 196.
    t = cyc;
    if64.in_PLANE = 2'd2;
    if64.in_START = 1'b1;
    push64(t, 2, 1 << 30);
    push64(t + 196, 2, 1 << 30);
    wait_cyc(t + 196);
    @(posedge clk); #1;
    if64.in_START = 1'b0;
    wait_cyc(t + 2*196 + 2);

    // Plane input changes mid-shift; the captured plane 0 must be used throughout.
    t = cyc;
    if64.in_PLANE = 2'd0;
    if64.in_START = 1'b1;
    push64(t, 0, 1 << 30);
    @(posedge clk); #1;
    if64.in_START = 1'b0;
    wait_cyc(t + 50);
    if64.in_PLANE = 2'd3;
    wait_cyc(t + 198);

    // Reset during column 30 abandons the plane without DONE.
    t = cyc;
    if64.in_PLANE = 2'd1;
    if64.in_START = 1'b1;
    push64(t, 1, t + 93);
    @(posedge clk); #1;
    if64.in_START = 1'b0;
    wait_cyc(t + 93);
    rst64 = 1'b1;
    @(posedge clk); #1;
    rst64 = 1'b0;
    shown64 = 1'b0;
    check("dut64 busy after reset", int'(if64.out_BUSY), 0);
    check("dut64 oe_n after reset", int'(if64.out_OE_N), 1);
    check("dut64 rd_addr after reset", int'(if64.out_RD_ADDR), 0);
    wait_cyc(t + 300);

    t = cyc;
    if64.in_PLANE = 2'd1;
    if64.in_START = 1'b1;
    push64(t, 1, 1 << 30);
    @(posedge clk); #1;
    if64.in_START = 1'b0;
    wait_cyc(t + 200);

    check("dut4 scoreboard drained", q4.size(), 0);
    check("dut64 scoreboard drained", q64.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/bcm_plane_shifter.md
Name: bcm_plane_shifter

Overview:
- Downstream consumer of the BCM timing controller's plane strobe.
- On each start request, reads one row of pixel words from the frame buffer and extracts the selected bit-plane. It then shifts that plane out to the HUB75 panel (RGB0/RGB1 + SCLK), latches it, and handles OE blanking.
- When the plane is latched it returns a one-cycle done pulse, which drives the BCM controller's in_CONTINUE.

Parameters:
- COLS, 64, columns per row shifted per plane (>=2)
- ADDR_W, 6, width of column address; 2**ADDR_W >= COLS
- PLANES, 4, bits per colour channel; power of two
- PLANE_W, 2, log2(PLANES)

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- in_START  in  1  start shifting one plane; sampled only in IDLE
- in_PLANE  in  PLANE_W  bit-plane index; captured with in_START
- out_RD_ADDR  out  ADDR_W  frame-buffer column address (= column counter)
- in_RD_DATA  in  6*PLANES  pixel word, valid 1 cycle after address; channel c (0=R0,1=G0,2=B0,3=R1,4=G1,5=B1) at [c*PLANES +: PLANES]
- out_RGB  out  6  panel data bits, bit c = channel c
- out_SCLK  out  1  panel shift clock
- out_LATCH  out  1  panel latch strobe
- out_OE_N  out  1  panel output enable, active low
- out_BUSY  out  1  high outside IDLE
- out_DONE  out  1  one-cycle pulse; plane latched

Behaviour:
- Reset (also mid-operation): state IDLE, col=0, captured plane=0, out_RGB=0, out_SCLK=0, out_LATCH=0, out_OE_N=1, out_DONE=0, out_BUSY=0, shown flag=0. Any shift in progress is abandoned with no DONE.
- States: IDLE, FETCH, LOAD, CLK_HI, LATCH, POST, DONE.
- IDLE: when in_START=1, capture in_PLANE, set col=0, go to FETCH. Otherwise stay in IDLE.
- FETCH: out_RD_ADDR=col, out_SCLK=0. Go to LOAD.
- LOAD: out_SCLK=0; in_RD_DATA is valid this cycle. At the clock edge, out_RGB[c] <= in_RD_DATA[c*PLANES+plane]. Go to CLK_HI.
- CLK_HI: out_SCLK=1. If col==COLS-1, go to LATCH; else col<=col+1 and go to FETCH.
- out_RGB stays stable from the start of CLK_HI until the end of the next LOAD, so data is stable around every SCLK rise.
- LATCH: out_LATCH=1, out_OE_N=1. Go to POST.
- POST: out_LATCH=0, out_OE_N=1; at the clock edge set shown=1. Go to DONE.
- DONE: out_DONE=1. Go to IDLE.
- out_OE_N=1 in LATCH and POST, and whenever shown=0. Otherwise out_OE_N=0: the previously latched plane is displayed while the next one shifts and during IDLE.
- out_SCLK, out_LATCH, out_OE_N, out_DONE and out_BUSY are decoded from state and shown only; they are glitch-free by one-hot or registered decode.
- Column timing: 3 cycles per column. If in_START is sampled at cycle t:
  - column k has SCLK high at t+3+3k;
  - LATCH at t+3*COLS+1, POST at t+3*COLS+2, DONE at t+3*COLS+3 (t+195 for COLS=64).
- in_START outside IDLE, including the DONE cycle, is ignored and not queued. in_START in the cycle after DONE (IDLE) is accepted.
- in_PLANE changes after capture have no effect on the plane in progress.
- out_RD_ADDR equals col in every state; it holds col=COLS-1 through LATCH/POST/DONE and returns to 0 at the next start.
- col is ADDR_W wide and never exceeds COLS-1; no wrap past COLS-1.

Test Plan:
- Reset, then idle 10 cycles -> out_OE_N=1, SCLK/LATCH/DONE/BUSY=0, RGB=0, RD_ADDR=0.
- COLS=4, PLANES=4; memory word for col k has R0=k, G0=~k, others 0; in_START at t with in_PLANE=1 -> 4 SCLK pulses at t+3, t+6, t+9, t+12; R0 bits 0,0,1,1 and G0 bits 1,1,0,0 at each rise; LATCH at t+13; DONE at t+15; OE_N=1 at t+13..t+14 and 0 from t+15.
- Default COLS=64, in_START with in_PLANE=3 -> exactly 64 SCLK pulses, 192 cycles shifting, single DONE at t+195, BUSY high t+1..t+195.
- in_START held high continuously -> restart in the cycle after each DONE. No start is accepted during BUSY, and DONE spacing is 3*COLS+4 cycles.
- in_PLANE toggled mid-shift -> output bits still come from the captured plane.
- rst asserted at column 30 -> next cycle IDLE, OE_N=1, no DONE. A fresh in_START afterwards produces a full 64-column sequence.
